// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog -- single-clock first-word-fall-through FIFO with
// programmable almost-full/almost-empty thresholds, live occupancy count,
// synchronous flush and sticky overflow/underflow flags.
//
// Optional feature macro: SYNC_FIFO_BYPASS_EN
//   defined   : zero-latency write-through while the FIFO is empty
//   undefined : registered outputs only, 1-cycle write-to-read latency
//
// Ports:
//   clk, rst (async, active-high), flush (sync clear)
//   wr_data/wr_en        -> write side, wr_full / wr_almost_full status
//   rd_en                -> pop; rd_data / rd_empty / rd_almost_empty status
//   count                -> words held, 0..DEPTH
//   overflow/underflow   -> sticky error flags, cleared by err_clr
module sync_fifo_prog #(
    parameter int DWIDTH        = 32,
    parameter int DEPTH         = 512,
    parameter int AFULL_THRESH  = DEPTH - 4,
    parameter int AEMPTY_THRESH = 4,
    parameter     RAM_STYLE     = "auto"
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [DWIDTH-1:0]        wr_data,
    input  logic                     wr_en,
    output logic                     wr_full,
    output logic                     wr_almost_full,
    input  logic                     rd_en,
    output logic [DWIDTH-1:0]        rd_data,
    output logic                     rd_empty,
    output logic                     rd_almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AE_CNT   = CW'(AEMPTY_THRESH);

    (* ram_style = RAM_STYLE *) logic [DWIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]     wr_ptr, rd_ptr, rd_ptr_n;
    logic [CW-1:0]     cnt_q, cnt_n;
    logic [AW-1:0]     rd_addr_n;
    logic [DWIDTH-1:0] rd_q;
    logic              empty_q, full_q, af_q, ae_q, ovf_q, udf_q;
    logic              push, pop, pass, rd_empty_int, fwd;

`ifdef SYNC_FIFO_BYPASS_EN
    // While empty, a write is visible on the read side in the same cycle;
    // if it is also popped it never touches the storage.
    assign pass         = empty_q & wr_en & rd_en;
    assign rd_empty_int = empty_q & ~wr_en;
    assign rd_data      = empty_q ? wr_data : rd_q;
`else
    assign pass         = 1'b0;
    assign rd_empty_int = empty_q;
    assign rd_data      = rd_q;
`endif

    // A write while full is dropped even if a pop happens the same cycle.
    assign push = wr_en & ~full_q & ~pass & ~flush;
    assign pop  = rd_en & ~empty_q & ~flush;

    assign rd_ptr_n  = rd_ptr + CW'(pop);
    assign rd_addr_n = rd_ptr_n[AW-1:0];

    // The word written this cycle becomes the head after the edge only when
    // the FIFO drains to it (empty, or 1 word with push+pop); forward it
    // since the array read returns the old contents.
    assign fwd = push && (wr_ptr[AW-1:0] == rd_addr_n);

    always_comb begin
        cnt_n = cnt_q;
        if (flush) begin
            cnt_n = '0;
        end else begin
            case ({push, pop})
                2'b10:   cnt_n = cnt_q + 1'b1;
                2'b01:   cnt_n = cnt_q - 1'b1;
                default: cnt_n = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // Output prefetch register: always holds the word at the next head.
    always_ff @(posedge clk) begin
        rd_q <= fwd ? wr_data : mem[rd_addr_n];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wr_ptr  <= flush ? '0 : wr_ptr + CW'(push);
            rd_ptr  <= flush ? '0 : rd_ptr_n;
            cnt_q   <= cnt_n;
            empty_q <= (cnt_n == '0);
            full_q  <= (cnt_n == FULL_CNT);
            af_q    <= (cnt_n >= AF_CNT);
            ae_q    <= (cnt_n <= AE_CNT);
            // A new error event wins over a same-cycle clear.
            ovf_q   <= (wr_en & full_q) | (ovf_q & ~err_clr);
            udf_q   <= (rd_en & rd_empty_int) | (udf_q & ~err_clr);
        end
    end

    assign count           = cnt_q;
    assign wr_full         = full_q;
    assign wr_almost_full  = af_q;
    assign rd_empty        = rd_empty_int;
    assign rd_almost_empty = ae_q;
    assign overflow        = ovf_q;
    assign underflow       = udf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
`timescale 1ns/1ps
// Scoreboard bench for sync_fifo_prog (DEPTH=16, DWIDTH=8).
// The driver pushes the expected visible state for each cycle into expq and
// then advances a queue-based reference model; a negedge monitor pops and
// compares against the DUT outputs.
module tb_sync_fifo_prog;

`ifdef SYNC_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int D  = 16;
    localparam int AF = 12;
    localparam int AE = 4;

    logic       clk = 1'b0;
    logic       rst, flush, wr_en, rd_en, err_clr;
    logic [7:0] wr_data, rd_data;
    logic       wr_full, wr_almost_full, rd_empty, rd_almost_empty;
    logic       overflow, underflow;
    logic [4:0] count;

    sync_fifo_prog #(
        .DWIDTH(8), .DEPTH(D), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE), .RAM_STYLE("auto")
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_data(wr_data), .wr_en(wr_en), .wr_full(wr_full), .wr_almost_full(wr_almost_full),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty), .rd_almost_empty(rd_almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cnt;
        bit         emp, full, af, ae, ovf, udf;
        logic [7:0] data;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] mq[$];
    bit         m_ovf, m_udf;
    int         ncmp = 0;
    int         nerr = 0;

    function automatic void chk(string nm, int act, int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("count", int'(count), e.cnt);
            chk("rd_empty", int'(rd_empty), int'(e.emp));
            chk("wr_full", int'(wr_full), int'(e.full));
            chk("wr_almost_full", int'(wr_almost_full), int'(e.af));
            chk("rd_almost_empty", int'(rd_almost_empty), int'(e.ae));
            chk("overflow", int'(overflow), int'(e.ovf));
            chk("underflow", int'(underflow), int'(e.udf));
            if (!e.emp) chk("rd_data", int'(rd_data), int'(e.data));
        end
    end

    // Drive one cycle: record what should be visible now, then apply the
    // cycle's effect to the reference model.
    task automatic drv(input bit we, input logic [7:0] wd, input bit re,
                       input bit fl, input bit ec);
        exp_t e;
        int   c;
        bit   remp, ovf_e, udf_e, pass;
        wr_en = we; wr_data = wd; rd_en = re; flush = fl; err_clr = ec;
        c    = mq.size();
        remp = (c == 0) && !(BYP && we);
        e.cnt = c; e.emp = remp; e.full = (c == D); e.af = (c >= AF); e.ae = (c <= AE);
        e.ovf = m_ovf; e.udf = m_udf;
        e.data = (c > 0) ? mq[0] : wd;
        expq.push_back(e);
        ovf_e = we && (c == D);
        udf_e = re && remp;
        if (fl) begin
            mq.delete();
        end else begin
            pass = BYP && (c == 0) && we && re;
            if (re && c > 0) void'(mq.pop_front());
            if (we && c < D && !pass) mq.push_back(wd);
        end
        m_ovf = ovf_e | (m_ovf & !ec);
        m_udf = udf_e | (m_udf & !ec);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        drv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fill_to(input int n);
        while (mq.size() < n) drv(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        while (mq.size() > 0) drv(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_rd_empty"}, int'(rd_empty), 1);
        chk({tag, "_wr_full"}, int'(wr_full), 0);
        chk({tag, "_afull"}, int'(wr_almost_full), 0);
        chk({tag, "_aempty"}, int'(rd_almost_empty), 1);
        chk({tag, "_ovf"}, int'(overflow), 0);
        chk({tag, "_udf"}, int'(underflow), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = 8'h00;
        m_ovf = 1'b0; m_udf = 1'b0;
        #12;
        chk_reset_vals("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        idle();

        // 0x1..0x4 back to back, no reads
        for (int i = 1; i <= 4; i++) drv(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        chk("count_after4", int'(count), 4);
        chk("head_after4", int'(rd_data), 1);
        drain();
        idle();

        // fill with 0..15, then a 17th write
        for (int i = 0; i < D; i++) drv(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        drv(1'b1, 8'd16, 1'b0, 1'b0, 1'b0);
        chk("full_count", int'(count), 16);
        chk("full_ovf", int'(overflow), 1);
        for (int i = 0; i < D; i++) begin
            chk("drain_order", int'(rd_data), i);
            drv(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        drv(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle();

        // sustained push+pop at fill levels 1 and 15
        fill_to(1);
        for (int i = 0; i < 100; i++) drv(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
        fill_to(15);
        for (int i = 0; i < 100; i++) drv(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
        drain();
        idle();

        // underflow, clear, then overflow concurrent with clear
        drv(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle();
        drv(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle();
        fill_to(D);
        drv(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        idle();
        drain();
        drv(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // async reset mid-burst at count 9
        fill_to(9);
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h3c;
        #2;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle();

        // flush at count 9
        fill_to(9);
        drv(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
        chk("flush_count", int'(count), 0);
        chk("flush_empty", int'(rd_empty), 1);
        idle();

        // write+read on an empty FIFO (write-through only with bypass)
        drv(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        idle();
        drv(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // random traffic with alternating fill bias
        for (int blk = 0; blk < 16; blk++) begin
            int wp;
            int rp;
            wp = (blk % 2 == 0) ? 75 : 35;
            rp = (blk % 2 == 0) ? 35 : 75;
            for (int i = 0; i < 200; i++) begin
                drv($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp,
                    $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 4);
            end
        end
        idle();
        @(negedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
